// File: rtl/regfile_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq_pkg
//  Description : Shared constants for the register-file sequencer: opcode
//                values, ALU add code, writeback mux codes and the FSM
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_seq_pkg;

   // Opcodes, Instruction[15:12]
   localparam logic [3:0] c_OP_RTYPE = 4'h0;
   localparam logic [3:0] c_OP_ADDI  = 4'h1;
   localparam logic [3:0] c_OP_MOVI  = 4'h2;
   localparam logic [3:0] c_OP_LOAD  = 4'h3;
   localparam logic [3:0] c_OP_STOR  = 4'h4;
   localparam logic [3:0] c_OP_HALT  = 4'hF;

   // ALU operation used for ADDI
   localparam logic [3:0] c_ALU_ADD = 4'h0;

   // Writeback mux select codes
   localparam logic [1:0] c_WB_ALU = 2'd0;
   localparam logic [1:0] c_WB_IMM = 2'd1;
   localparam logic [1:0] c_WB_MEM = 2'd2;

   // Sequencer states
   typedef enum logic [2:0] {
      c_ST_FETCH   = 3'd0,
      c_ST_DECODE  = 3'd1,
      c_ST_EXECUTE = 3'd2,
      c_ST_MEM     = 3'd3,
      c_ST_HALT    = 3'd4
   } seqStateT;

endpackage
`default_nettype wire

// File: rtl/regfile_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_seq_if
//  Description : Bus bundle between the sequencer and its environment
//                (instruction memory, data memory, RegFile + ALU datapath).
//  Ports       : master - sequencer side (drives fetch/mem requests and all
//                         datapath controls)
//                slave  - environment side (drives acks and Instruction)
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_seq_if #(
   parameter int DATA_WIDTH = 16,
   parameter int SEL_WIDTH  = 4
);
   logic                  FetchAck;
   logic [DATA_WIDTH-1:0] Instruction;
   logic                  MemAck;
   logic                  FetchReq;
   logic [DATA_WIDTH-1:0] ProgramCounter;
   logic [SEL_WIDTH-1:0]  SelectA;
   logic [SEL_WIDTH-1:0]  SelectB;
   logic [SEL_WIDTH-1:0]  SelectInput;
   logic                  WriteEnable;
   logic [3:0]            AluOp;
   logic                  UseImm;
   logic [DATA_WIDTH-1:0] Immediate;
   logic [1:0]            WbSel;
   logic                  MemReq;
   logic                  MemWrite;
   logic                  Halted;
   logic                  IllegalInst;

   modport master (
      input  FetchAck, Instruction, MemAck,
      output FetchReq, ProgramCounter, SelectA, SelectB, SelectInput,
             WriteEnable, AluOp, UseImm, Immediate, WbSel, MemReq,
             MemWrite, Halted, IllegalInst
   );

   modport slave (
      output FetchAck, Instruction, MemAck,
      input  FetchReq, ProgramCounter, SelectA, SelectB, SelectInput,
             WriteEnable, AluOp, UseImm, Immediate, WbSel, MemReq,
             MemWrite, Halted, IllegalInst
   );
endinterface
`default_nettype wire

// File: rtl/regfile_sequencer_instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Purely combinational instruction decode. Splits the word
//                into register selects, derives ALU controls, the extended
//                immediate, the writeback select and instruction class flags.
//  Ports       : i_instruction  - raw instruction word
//                o_selectA/B    - Rd / Rs fields
//                o_aluOp, o_useImm, o_immediate, o_wbSel - datapath controls
//                o_isRegWrite   - RTYPE/ADDI/MOVI (writes Rd in EXECUTE)
//                o_isLoad/o_isStore/o_isHalt/o_isIllegal - class flags
//  Revision    : 1.0  initial release
// ============================================================================
module instr_decoder
   import regfile_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SEL_WIDTH  = 4
) (
   input  logic [DATA_WIDTH-1:0] i_instruction,
   output logic [SEL_WIDTH-1:0]  o_selectA,
   output logic [SEL_WIDTH-1:0]  o_selectB,
   output logic [3:0]            o_aluOp,
   output logic                  o_useImm,
   output logic [DATA_WIDTH-1:0] o_immediate,
   output logic [1:0]            o_wbSel,
   output logic                  o_isRegWrite,
   output logic                  o_isLoad,
   output logic                  o_isStore,
   output logic                  o_isHalt,
   output logic                  o_isIllegal
);

   logic [3:0] w_opcode;
   logic [3:0] w_ext;
   logic [7:0] w_imm8;

   assign w_opcode  = i_instruction[15:12];
   assign w_ext     = i_instruction[7:4];
   assign w_imm8    = i_instruction[7:0];
   assign o_selectA = i_instruction[11:8];
   assign o_selectB = i_instruction[3:0];

   always_comb begin
      o_aluOp      = c_ALU_ADD;
      o_useImm     = 1'b0;
      o_immediate  = '0;
      o_wbSel      = c_WB_ALU;
      o_isRegWrite = 1'b0;
      o_isLoad     = 1'b0;
      o_isStore    = 1'b0;
      o_isHalt     = 1'b0;
      o_isIllegal  = 1'b0;
      case (w_opcode)
         c_OP_RTYPE: begin
            o_aluOp      = w_ext;
            o_isRegWrite = 1'b1;
         end
         c_OP_ADDI: begin
            o_useImm     = 1'b1;
            o_immediate  = {{(DATA_WIDTH-8){w_imm8[7]}}, w_imm8};
            o_isRegWrite = 1'b1;
         end
         c_OP_MOVI: begin
            o_immediate  = {{(DATA_WIDTH-8){1'b0}}, w_imm8};
            o_wbSel      = c_WB_IMM;
            o_isRegWrite = 1'b1;
         end
         c_OP_LOAD: begin
            o_wbSel  = c_WB_MEM;
            o_isLoad = 1'b1;
         end
         c_OP_STOR: o_isStore   = 1'b1;
         c_OP_HALT: o_isHalt    = 1'b1;
         default:   o_isIllegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXECUTE/MEM/HALT controller for
//                the 16x16 RegFile + ALU datapath.
//  Ports       : Clock - rising-edge clock
//                Reset - synchronous, active-high
//                bus   - regfile_seq_if.master: fetch handshake
//                        (FetchReq/FetchAck/Instruction/ProgramCounter),
//                        data-memory handshake (MemReq/MemWrite/MemAck),
//                        RegFile selects and WriteEnable, ALU controls,
//                        writeback select, Halted and IllegalInst.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    SEL_WIDTH  = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic          Clock,
   input  logic          Reset,
   regfile_seq_if.master bus
);

   // Decoder outputs (decoding the word on the bus during FETCH)
   logic [SEL_WIDTH-1:0]  w_selectA;
   logic [SEL_WIDTH-1:0]  w_selectB;
   logic [3:0]            w_aluOp;
   logic                  w_useImm;
   logic [DATA_WIDTH-1:0] w_immediate;
   logic [1:0]            w_wbSel;
   logic                  w_isRegWrite;
   logic                  w_isLoad;
   logic                  w_isStore;
   logic                  w_isHalt;
   logic                  w_isIllegal;

   // Sequencer state and registered outputs
   seqStateT              r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic                  r_fetchReq;
   logic [SEL_WIDTH-1:0]  r_selectA;
   logic [SEL_WIDTH-1:0]  r_selectB;
   logic [SEL_WIDTH-1:0]  r_selectInput;
   logic                  r_writeEnable;
   logic [3:0]            r_aluOp;
   logic                  r_useImm;
   logic [DATA_WIDTH-1:0] r_immediate;
   logic [1:0]            r_wbSel;
   logic                  r_memReq;
   logic                  r_memWrite;
   logic                  r_halted;
   logic                  r_illegalInst;
   // Class flags of the latched instruction
   logic                  r_isRegWrite;
   logic                  r_isLoad;
   logic                  r_isStore;
   logic                  r_isHalt;
   logic                  r_isIllegal;

   logic                  w_loadWrite;

   instr_decoder #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH)
   ) uDecoder (
      .i_instruction (bus.Instruction),
      .o_selectA     (w_selectA),
      .o_selectB     (w_selectB),
      .o_aluOp       (w_aluOp),
      .o_useImm      (w_useImm),
      .o_immediate   (w_immediate),
      .o_wbSel       (w_wbSel),
      .o_isRegWrite  (w_isRegWrite),
      .o_isLoad      (w_isLoad),
      .o_isStore     (w_isStore),
      .o_isHalt      (w_isHalt),
      .o_isIllegal   (w_isIllegal)
   );

   // Load data is only valid in the MemAck cycle itself, so the load
   // writeback strobe has to follow MemAck combinationally.
   assign w_loadWrite = (r_state == c_ST_MEM) && r_isLoad && bus.MemAck;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state       <= c_ST_FETCH;
         r_pc          <= RESET_PC;
         r_fetchReq    <= 1'b1;
         r_selectA     <= '0;
         r_selectB     <= '0;
         r_selectInput <= '0;
         r_writeEnable <= 1'b0;
         r_aluOp       <= '0;
         r_useImm      <= 1'b0;
         r_immediate   <= '0;
         r_wbSel       <= c_WB_ALU;
         r_memReq      <= 1'b0;
         r_memWrite    <= 1'b0;
         r_halted      <= 1'b0;
         r_illegalInst <= 1'b0;
         r_isRegWrite  <= 1'b0;
         r_isLoad      <= 1'b0;
         r_isStore     <= 1'b0;
         r_isHalt      <= 1'b0;
         r_isIllegal   <= 1'b0;
      end else begin
         case (r_state)
            c_ST_FETCH: begin
               if (bus.FetchAck) begin
                  // Latch the decoded word so the datapath controls are
                  // already valid while in DECODE and stay put until the
                  // next fetch is accepted.
                  r_fetchReq   <= 1'b0;
                  r_pc         <= r_pc + 1'b1;
                  r_selectA    <= w_selectA;
                  r_selectB    <= w_selectB;
                  r_aluOp      <= w_aluOp;
                  r_useImm     <= w_useImm;
                  r_immediate  <= w_immediate;
                  r_wbSel      <= w_wbSel;
                  r_isRegWrite <= w_isRegWrite;
                  r_isLoad     <= w_isLoad;
                  r_isStore    <= w_isStore;
                  r_isHalt     <= w_isHalt;
                  r_isIllegal  <= w_isIllegal;
                  r_state      <= c_ST_DECODE;
               end
            end

            c_ST_DECODE: begin
               if (r_isRegWrite || r_isLoad) begin
                  r_selectInput <= r_selectA;
               end
               r_writeEnable <= r_isRegWrite;
               r_illegalInst <= r_isIllegal;
               r_state       <= c_ST_EXECUTE;
            end

            c_ST_EXECUTE: begin
               r_writeEnable <= 1'b0;
               r_illegalInst <= 1'b0;
               if (r_isLoad || r_isStore) begin
                  r_memReq   <= 1'b1;
                  r_memWrite <= r_isStore;
                  r_state    <= c_ST_MEM;
               end else if (r_isHalt) begin
                  r_halted <= 1'b1;
                  r_state  <= c_ST_HALT;
               end else begin
                  r_fetchReq <= 1'b1;
                  r_state    <= c_ST_FETCH;
               end
            end

            c_ST_MEM: begin
               if (bus.MemAck) begin
                  r_memReq   <= 1'b0;
                  r_memWrite <= 1'b0;
                  r_fetchReq <= 1'b1;
                  r_state    <= c_ST_FETCH;
               end
            end

            c_ST_HALT: begin
               r_state <= c_ST_HALT;
            end

            default: begin
               // Unreachable encodings recover to a clean fetch
               r_writeEnable <= 1'b0;
               r_illegalInst <= 1'b0;
               r_memReq      <= 1'b0;
               r_memWrite    <= 1'b0;
               r_fetchReq    <= 1'b1;
               r_state       <= c_ST_FETCH;
            end
         endcase
      end
   end

   assign bus.FetchReq       = r_fetchReq;
   assign bus.ProgramCounter = r_pc;
   assign bus.SelectA        = r_selectA;
   assign bus.SelectB        = r_selectB;
   assign bus.SelectInput    = r_selectInput;
   assign bus.WriteEnable    = r_writeEnable | w_loadWrite;
   assign bus.AluOp          = r_aluOp;
   assign bus.UseImm         = r_useImm;
   assign bus.Immediate      = r_immediate;
   assign bus.WbSel          = r_wbSel;
   assign bus.MemReq         = r_memReq;
   assign bus.MemWrite       = r_memWrite;
   assign bus.Halted         = r_halted;
   assign bus.IllegalInst    = r_illegalInst;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sequencer
//  Description : Directed self-checking bench for regfile_sequencer.
//                Register writes are predicted into a queue when an
//                instruction is issued and popped when WriteEnable fires.
//                A second instance with RESET_PC=16'hFFFF covers PC wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_sequencer;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      logic [3:0]  sel;
      logic [1:0]  wb;
      logic [15:0] imm;
      bit          chkImm;
   } wrExpT;

   wrExpT expQ[$];

   regfile_seq_if bus  ();
   regfile_seq_if bus2 ();

   regfile_sequencer dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   regfile_sequencer #(.RESET_PC(16'hFFFF)) dutWrap (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pushWrite(input logic [3:0] sel, input logic [1:0] wb,
                            input logic [15:0] imm, input bit chkImm);
      wrExpT e;
      e.sel = sel; e.wb = wb; e.imm = imm; e.chkImm = chkImm;
      expQ.push_back(e);
   endtask

   // Waits (bounded) for a fetch request, presents instr for exactly one
   // accept edge; returns just after the edge, DUT is then in DECODE.
   task automatic fetchInstr(input logic [15:0] instr);
      int n = 0;
      @(negedge clk);
      while (bus.FetchReq !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("fetch_wait", {31'd0, bus.FetchReq}, 32'd1);
      bus.Instruction = instr;
      bus.FetchAck    = 1'b1;
      @(posedge clk);
      #1;
      bus.FetchAck = 1'b0;
   endtask

   // Write scoreboard
   always @(negedge clk) begin
      if (bus.WriteEnable === 1'b1) begin
         checks++;
         assert (expQ.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_write observed=sel%0h expected=no_write", bus.SelectInput);
         end
         if (expQ.size() != 0) begin
            wrExpT e;
            e = expQ.pop_front();
            check("wr_sel", {28'd0, bus.SelectInput}, {28'd0, e.sel});
            check("wr_wbsel", {30'd0, bus.WbSel}, {30'd0, e.wb});
            if (e.chkImm) check("wr_imm", {16'd0, bus.Immediate}, {16'd0, e.imm});
         end
      end
   end

   initial begin
      int violations;
      rst              = 1'b1;
      bus.FetchAck     = 1'b0;
      bus.MemAck       = 1'b0;
      bus.Instruction  = 16'h0000;
      bus2.FetchAck    = 1'b1;
      bus2.MemAck      = 1'b0;
      bus2.Instruction = 16'h2000;

      // ---- reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_fetchreq", {31'd0, bus.FetchReq}, 32'd1);
      check("rst_pc", {16'd0, bus.ProgramCounter}, 32'h0000);
      check("rst_we", {31'd0, bus.WriteEnable}, 32'd0);
      check("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
      check("rst_halted", {31'd0, bus.Halted}, 32'd0);
      check("rst_illegal", {31'd0, bus.IllegalInst}, 32'd0);
      check("rst_imm", {16'd0, bus.Immediate}, 32'd0);
      check("rst_wrap_pc", {16'd0, bus2.ProgramCounter}, 32'hFFFF);

      // ---- MOVI R5,0x25 with FetchAck held high
      rst             = 1'b0;
      bus.Instruction = 16'h2525;
      bus.FetchAck    = 1'b1;
      pushWrite(4'd5, 2'd1, 16'h0025, 1'b1);
      @(negedge clk);                                   // DECODE
      check("movi_fetchreq", {31'd0, bus.FetchReq}, 32'd0);
      check("movi_pc", {16'd0, bus.ProgramCounter}, 32'h0001);
      check("movi_selA", {28'd0, bus.SelectA}, 32'd5);
      check("movi_wbsel", {30'd0, bus.WbSel}, 32'd1);
      check("movi_imm", {16'd0, bus.Immediate}, 32'h0025);
      check("movi_we_decode", {31'd0, bus.WriteEnable}, 32'd0);
      check("wrap_pc", {16'd0, bus2.ProgramCounter}, 32'h0000);
      @(negedge clk);                                   // EXECUTE
      check("movi_we", {31'd0, bus.WriteEnable}, 32'd1);
      check("movi_pc_hold", {16'd0, bus.ProgramCounter}, 32'h0001);

      // ---- ADDI R5,-1 (FetchAck still high)
      bus.Instruction = 16'h15FF;
      pushWrite(4'd5, 2'd0, 16'hFFFF, 1'b1);
      @(negedge clk);                                   // FETCH
      check("movi_we_once", {31'd0, bus.WriteEnable}, 32'd0);
      check("addi_fetchreq", {31'd0, bus.FetchReq}, 32'd1);
      @(negedge clk);                                   // DECODE
      check("addi_selA", {28'd0, bus.SelectA}, 32'd5);
      check("addi_useimm", {31'd0, bus.UseImm}, 32'd1);
      check("addi_aluop", {28'd0, bus.AluOp}, 32'd0);
      check("addi_imm", {16'd0, bus.Immediate}, 32'hFFFF);
      check("addi_pc", {16'd0, bus.ProgramCounter}, 32'h0002);
      bus.FetchAck = 1'b0;

      // ---- RTYPE R7 <= R7 op3 R6
      pushWrite(4'd7, 2'd0, 16'h0000, 1'b0);
      fetchInstr(16'h0736);
      @(negedge clk);
      check("rtype_aluop", {28'd0, bus.AluOp}, 32'd3);
      check("rtype_selA", {28'd0, bus.SelectA}, 32'd7);
      check("rtype_selB", {28'd0, bus.SelectB}, 32'd6);
      check("rtype_useimm", {31'd0, bus.UseImm}, 32'd0);

      // ---- LOAD R12,[R5] with MemAck in the third MEM cycle
      pushWrite(4'd12, 2'd2, 16'h0000, 1'b0);
      fetchInstr(16'h3C05);
      @(posedge clk);                                   // -> EXECUTE
      @(posedge clk);                                   // -> MEM
      @(negedge clk);
      check("load_memreq1", {31'd0, bus.MemReq}, 32'd1);
      check("load_memwrite", {31'd0, bus.MemWrite}, 32'd0);
      check("load_we_wait", {31'd0, bus.WriteEnable}, 32'd0);
      check("load_selB", {28'd0, bus.SelectB}, 32'd5);
      @(negedge clk);
      check("load_memreq2", {31'd0, bus.MemReq}, 32'd1);
      @(posedge clk); #1;
      bus.MemAck = 1'b1;
      @(negedge clk);
      check("load_memreq3", {31'd0, bus.MemReq}, 32'd1);
      check("load_we_ack", {31'd0, bus.WriteEnable}, 32'd1);
      @(posedge clk); #1;
      bus.MemAck = 1'b0;
      @(negedge clk);
      check("load_memreq_off", {31'd0, bus.MemReq}, 32'd0);
      check("load_fetchreq", {31'd0, bus.FetchReq}, 32'd1);

      // ---- zero-wait LOAD R1,[R4]; MemAck high the whole time
      bus.MemAck = 1'b1;
      pushWrite(4'd1, 2'd2, 16'h0000, 1'b0);
      fetchInstr(16'h3104);
      @(negedge clk);                                   // DECODE
      @(negedge clk);                                   // EXECUTE
      check("zw_memreq_exec", {31'd0, bus.MemReq}, 32'd0);
      @(negedge clk);                                   // MEM (ack)
      check("zw_memreq", {31'd0, bus.MemReq}, 32'd1);
      check("zw_we", {31'd0, bus.WriteEnable}, 32'd1);
      @(posedge clk); #1;
      bus.MemAck = 1'b0;
      @(negedge clk);
      check("zw_memreq_off", {31'd0, bus.MemReq}, 32'd0);

      // ---- STOR then Reset while waiting in MEM
      fetchInstr(16'h4705);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("stor_memreq", {31'd0, bus.MemReq}, 32'd1);
      check("stor_memwrite", {31'd0, bus.MemWrite}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmem_memreq", {31'd0, bus.MemReq}, 32'd0);
      check("rstmem_memwrite", {31'd0, bus.MemWrite}, 32'd0);
      check("rstmem_pc", {16'd0, bus.ProgramCounter}, 32'h0000);
      check("rstmem_fetchreq", {31'd0, bus.FetchReq}, 32'd1);
      check("rstmem_selA", {28'd0, bus.SelectA}, 32'd0);

      // ---- illegal opcode
      fetchInstr(16'h9000);
      @(posedge clk);
      @(negedge clk);
      check("ill_pulse", {31'd0, bus.IllegalInst}, 32'd1);
      check("ill_we", {31'd0, bus.WriteEnable}, 32'd0);
      @(negedge clk);
      check("ill_pulse_end", {31'd0, bus.IllegalInst}, 32'd0);
      check("ill_fetchreq", {31'd0, bus.FetchReq}, 32'd1);
      check("ill_pc", {16'd0, bus.ProgramCounter}, 32'h0001);

      // ---- HALT, then FetchAck offered for 20 cycles
      fetchInstr(16'hF000);
      bus.FetchAck = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("halt_halted", {31'd0, bus.Halted}, 32'd1);
      violations = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.FetchReq !== 1'b0 || bus.WriteEnable !== 1'b0 ||
             bus.MemReq !== 1'b0 || bus.IllegalInst !== 1'b0 ||
             bus.Halted !== 1'b1 || bus.ProgramCounter !== 16'h0002)
            violations++;
      end
      check("halt_stable", violations, 32'd0);
      bus.FetchAck = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("halt_rst_halted", {31'd0, bus.Halted}, 32'd0);
      check("halt_rst_fetchreq", {31'd0, bus.FetchReq}, 32'd1);

      check("sb_empty", expQ.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
